// File: rtl/freq_limit_scanner_pkg.sv
// Shared types for the frequency-limit scanner: scan FSM states and arming helpers.
package freq_limit_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  // Macro-cycle changes required before the result RAM is trusted.
  localparam logic [1:0] ARM_LEVEL = 2'd2;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/freq_limit_bank.sv
// Per-channel low/high limit registers with a write port and a combinational
// compare of one channel's frequency result against its limits.
module freq_limit_bank #(
  parameter int unsigned NCH = 8,
  parameter int unsigned AW  = 3,
  parameter int unsigned uw  = 28
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          lim_we_i,
  input  logic [AW-1:0] lim_addr_i,
  input  logic          lim_sel_i,
  input  logic [uw-1:0] lim_data_i,
  input  logic [AW-1:0] cmp_idx_i,
  input  logic [uw-1:0] freq_i,
  output logic          hit_low_o,
  output logic          hit_high_o
);

  logic [uw-1:0] lo_q [NCH];
  logic [uw-1:0] hi_q [NCH];
  logic [uw-1:0] lo_sel;
  logic [uw-1:0] hi_sel;
  logic          enabled;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        lo_q[i] <= '0;
        hi_q[i] <= '0;
      end
    end else if (lim_we_i) begin
      if (lim_sel_i) hi_q[lim_addr_i] <= lim_data_i;
      else           lo_q[lim_addr_i] <= lim_data_i;
    end
  end

  // A zero high limit marks the channel as unused.
  always_comb begin
    lo_sel     = lo_q[cmp_idx_i];
    hi_sel     = hi_q[cmp_idx_i];
    enabled    = |hi_sel;
    hit_low_o  = enabled && (freq_i < lo_sel);
    hit_high_o = enabled && (freq_i > hi_sel);
  end

endmodule

// File: rtl/freq_limit_scanner.sv
// Scans the frequency-counter result RAM after every counter state change and
// raises sticky per-channel alarms for results outside the programmed limits.
module freq_limit_scanner
  import freq_limit_scanner_pkg::*;
#(
  parameter int unsigned NCH = 8,
  parameter int unsigned AW  = 3,
  parameter int unsigned uw  = 28,
  parameter int unsigned NA  = 3,
  parameter int unsigned cw  = 3
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic [NA+cw-1:0] source_state,
  output logic [AW-1:0]    addr,
  input  logic [uw-1:0]    frequency,
  input  logic             lim_we,
  input  logic [AW-1:0]    lim_addr,
  input  logic             lim_sel,
  input  logic [uw-1:0]    lim_data,
  input  logic [NCH-1:0]   alarm_clear,
  output logic [NCH-1:0]   alarm_low,
  output logic [NCH-1:0]   alarm_high,
  output logic             alarm_any,
  output logic             scan_done,
  output logic             busy,
  output logic             armed
);

  localparam logic [AW-1:0] LAST = AW'(NCH - 1);

  scan_state_e      state_q;
  logic [AW-1:0]    addr_q;
  logic [NA+cw-1:0] src_q;
  logic             pending_q;
  logic [1:0]       arm_cnt_q;
  logic [1:0]       arm_cnt_d;
  logic             armed_q;
  logic [AW-1:0]    cmp_idx_q;
  logic             cmp_valid_q;
  logic [NCH-1:0]   alarm_low_q;
  logic [NCH-1:0]   alarm_low_d;
  logic [NCH-1:0]   alarm_high_q;
  logic [NCH-1:0]   alarm_high_d;
  logic             alarm_any_q;
  logic             scan_done_q;
  logic             busy_q;
  logic             change;
  logic             macro_chg;
  logic             hit_low;
  logic             hit_high;

  freq_limit_bank #(
    .NCH (NCH),
    .AW  (AW),
    .uw  (uw)
  ) u_bank (
    .clk_i      (refclk),
    .rst_i      (rst),
    .lim_we_i   (lim_we),
    .lim_addr_i (lim_addr),
    .lim_sel_i  (lim_sel),
    .lim_data_i (lim_data),
    .cmp_idx_i  (cmp_idx_q),
    .freq_i     (frequency),
    .hit_low_o  (hit_low),
    .hit_high_o (hit_high)
  );

  always_comb begin
    change    = (source_state != src_q);
    macro_chg = (source_state[NA+cw-1:NA] != src_q[NA+cw-1:NA]);
    arm_cnt_d = macro_chg ? sat_inc2(arm_cnt_q) : arm_cnt_q;
  end

  // Clear applies to all channels; the compared channel's set is OR'd in after, so set wins.
  always_comb begin
    alarm_low_d  = alarm_low_q & ~alarm_clear;
    alarm_high_d = alarm_high_q & ~alarm_clear;
    if (cmp_valid_q && armed_q) begin
      alarm_low_d[cmp_idx_q]  = alarm_low_d[cmp_idx_q] | hit_low;
      alarm_high_d[cmp_idx_q] = alarm_high_d[cmp_idx_q] | hit_high;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      src_q        <= '0;
      pending_q    <= 1'b0;
      arm_cnt_q    <= '0;
      armed_q      <= 1'b0;
      cmp_idx_q    <= '0;
      cmp_valid_q  <= 1'b0;
      alarm_low_q  <= '0;
      alarm_high_q <= '0;
      alarm_any_q  <= 1'b0;
      scan_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      src_q        <= source_state;
      arm_cnt_q    <= arm_cnt_d;
      armed_q      <= armed_q | (arm_cnt_d >= ARM_LEVEL);
      cmp_idx_q    <= addr_q;
      cmp_valid_q  <= (state_q == ST_ISSUE);
      alarm_low_q  <= alarm_low_d;
      alarm_high_q <= alarm_high_d;
      alarm_any_q  <= (|alarm_low_q) | (|alarm_high_q);
      scan_done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          addr_q <= '0;
          if (change || pending_q) begin
            state_q   <= ST_ISSUE;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (change) pending_q <= 1'b1;
          if (addr_q == LAST) begin
            addr_q  <= '0;
            state_q <= ST_DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (change) pending_q <= 1'b1;
          state_q     <= ST_DONE;
          busy_q      <= 1'b0;
          scan_done_q <= 1'b1;
        end
        ST_DONE: begin
          if (change) pending_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign addr       = addr_q;
  assign alarm_low  = alarm_low_q;
  assign alarm_high = alarm_high_q;
  assign alarm_any  = alarm_any_q;
  assign scan_done  = scan_done_q;
  assign busy       = busy_q;
  assign armed      = armed_q;

endmodule
